// File: rtl/puzzle_picker.sv
// Picks a 4-bit puzzle index per new-game request: an LFSR sets the start and a
// history mask forbids repeats until all 16 indices have been dealt.
module puzzle_picker #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_game,
    output logic [3:0] index,
    output logic       index_valid,
    output logic       busy,
    output logic [4:0] sets_left
);

    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] FULL_MASK = 16'hFFFF;
    localparam logic [4:0]  SETS_ALL  = 5'd16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [15:0] lfsr;
    logic [15:0] used_mask, used_mask_d;
    logic [15:0] cand_bit, merged;
    logic [3:0]  cand, cand_d, index_d;
    logic [4:0]  sets_d;
    logic        busy_d, valid_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next state, probe/accept decisions and next output values
    always_comb begin
        state_d     = state;
        cand_d      = cand;
        index_d     = index;
        used_mask_d = used_mask;
        sets_d      = sets_left;
        cand_bit    = 16'(1) << cand;
        merged      = used_mask | cand_bit;
        case (state)
            IDLE: begin
                if (new_game) begin
                    cand_d  = lfsr[3:0];
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (!used_mask[cand]) begin
                    index_d = cand;
                    state_d = DONE;
                    // Round ends: keep only the just-dealt index so it cannot repeat next
                    if (merged == FULL_MASK) begin
                        used_mask_d = cand_bit;
                        sets_d      = 5'd15;
                    end else begin
                        used_mask_d = merged;
                        sets_d      = sets_left - 5'd1;
                    end
                end else begin
                    cand_d = cand + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == DONE);
    end

    // Datapath and registered outputs; the LFSR free-runs in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr        <= SEED_EFF;
            cand        <= 4'd0;
            index       <= 4'd0;
            used_mask   <= 16'h0000;
            sets_left   <= SETS_ALL;
            busy        <= 1'b0;
            index_valid <= 1'b0;
        end else begin
            lfsr        <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
            cand        <= cand_d;
            index       <= index_d;
            used_mask   <= used_mask_d;
            sets_left   <= sets_d;
            busy        <= busy_d;
            index_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_puzzle_picker.sv
// Randomized self-checking bench for puzzle_picker against a set-based model of
// dealing without repetition.
module tb_puzzle_picker;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk;
    logic       rst_n;
    logic       new_game;
    logic [3:0] index;
    logic       index_valid;
    logic       busy;
    logic [4:0] sets_left;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    bit          used [16];
    logic [3:0]  last_idx;

    puzzle_picker #(.SEED(SEED)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_game   (new_game),
        .index      (index),
        .index_valid(index_valid),
        .busy       (busy),
        .sets_left  (sets_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running pseudo-random source as described by its polynomial
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    function automatic int used_count();
        int n = 0;
        for (int i = 0; i < 16; i++) if (used[i]) n++;
        return n;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) used[i] = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        new_game = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One pick starting from a negedge with the DUT idle; ends at the idle negedge after DONE
    task automatic do_pick(input bit hold, input bit junk);
        logic [3:0] c;
        int         k, edges, exp_sets;
        bit         got;
        c = m_lfsr[3:0];
        k = 0;
        while (used[c] && k < 16) begin
            c = c + 4'd1;
            k++;
        end
        new_game = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pick_busy_rise: busy=%b required 1", busy);
        end
        if (!hold) new_game = junk ? 1'($urandom % 2) : 1'b0;
        edges = 0;
        got   = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            edges++;
            if (index_valid === 1'b1) got = 1;
            if (!hold && junk) new_game = 1'($urandom % 2);
        end
        used[c] = 1'b1;
        if (used_count() == 16) begin
            clear_model();
            used[c] = 1'b1;
        end
        exp_sets = 16 - used_count();
        checks++;
        if (!got || edges != k + 1) begin
            errors++;
            $display("FAIL pick_latency: edges=%0d strobe=%0d required edges=%0d", edges, got, k + 1);
        end
        checks++;
        if (index !== c) begin
            errors++;
            $display("FAIL pick_index: index=%0d required %0d", index, c);
        end
        checks++;
        if (sets_left !== 5'(exp_sets)) begin
            errors++;
            $display("FAIL pick_sets_left: sets_left=%0d required %0d", sets_left, exp_sets);
        end
        @(negedge clk);
        if (!hold) new_game = 1'b0;
        checks++;
        if (index_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pick_strobe_end: index_valid=%b busy=%b required 0 0", index_valid, busy);
        end
        if (!hold) begin
            @(negedge clk);
            checks++;
            if (index_valid !== 1'b0 || index !== c) begin
                errors++;
                $display("FAIL pick_hold: index_valid=%b index=%0d required 0 %0d", index_valid, index, c);
            end
        end
        last_idx = c;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        new_game = 1'b0;
        clear_model();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            new_game = 1'($urandom % 2);
            checks++;
            if (index !== 4'd0 || index_valid !== 1'b0 || busy !== 1'b0 || sets_left !== 5'd16) begin
                errors++;
                $display("FAIL reset_values: index=%0d valid=%b busy=%b sets_left=%0d required 0 0 0 16",
                         index, index_valid, busy, sets_left);
            end
        end
        new_game = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || index_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: busy=%b valid=%b required 0 0", busy, index_valid);
            end
        end
    endtask

    task automatic test_first_pick();
        apply_reset();
        do_pick(1'b0, 1'b0);
        checks++;
        if (index !== 4'd1 || sets_left !== 5'd15) begin
            errors++;
            $display("FAIL first_pick: index=%0d sets_left=%0d required 1 15", index, sets_left);
        end
    endtask

    task automatic test_full_round();
        bit         seen [16];
        logic [3:0] prev;
        int         missing;
        apply_reset();
        for (int i = 0; i < 16; i++) seen[i] = 1'b0;
        for (int p = 0; p < 16; p++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_pick(1'b0, 1'b0);
            seen[index] = 1'b1;
        end
        missing = 0;
        for (int i = 0; i < 16; i++) if (!seen[i]) missing++;
        checks++;
        if (missing != 0 || sets_left !== 5'd15) begin
            errors++;
            $display("FAIL full_round: missing=%0d sets_left=%0d required 0 15", missing, sets_left);
        end
        prev = index;
        do_pick(1'b0, 1'b0);
        checks++;
        if (index === prev) begin
            errors++;
            $display("FAIL round_boundary: index=%0d equals previous %0d", index, prev);
        end
    endtask

    task automatic test_busy_pulses();
        for (int p = 0; p < 20; p++) do_pick(1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 20; p++) do_pick(1'b1, 1'b0);
        new_game = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_search();
        int strobes;
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pre: busy=%b required 1", busy);
        end
        #1 rst_n = 1'b0;
        clear_model();
        #1;
        checks++;
        if (index !== 4'd0 || index_valid !== 1'b0 || busy !== 1'b0 || sets_left !== 5'd16) begin
            errors++;
            $display("FAIL mid_reset_async: index=%0d valid=%b busy=%b sets_left=%0d required 0 0 0 16",
                     index, index_valid, busy, sets_left);
        end
        strobes = 0;
        repeat (4) begin
            @(negedge clk);
            if (index_valid !== 1'b0) strobes++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (index_valid !== 1'b0) strobes++;
        end
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL mid_reset_strobe: strobes=%0d required 0", strobes);
        end
        do_pick(1'b0, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        new_game = 1'b0;
        last_idx = 4'd0;
        test_reset();
        test_first_pick();
        test_full_round();
        test_busy_pulses();
        test_back_to_back();
        for (int i = 0; i < 5; i++) do_pick(1'b0, 1'b0);
        test_reset_mid_search();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
